// File: rtl/comp_pulse_seq.sv
// Timing-pulse sequencer for a latch-based ones-complementer: registers the operand,
// then issues one-hot pulses (clear, then set bit 0..N_BITS-1), each HOLD cycles wide.
module comp_pulse_seq #(
    parameter int N_BITS = 8,
    parameter int PULSES = 9,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_BITS-1:0] b_in,
    output logic [N_BITS-1:0] b_out,
    output logic [PULSES-1:0] T,
    output logic              busy,
    output logic              done
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int IDX_W  = (PULSES > 1) ? $clog2(PULSES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SET  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [PULSES-1:0]   t_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [N_BITS-1:0]   b_out_nxt;

    // Reset also clears the pulse register, so T drops without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            idx      <= '0;
            T        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            b_out    <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            idx      <= idx_nxt;
            T        <= t_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            b_out    <= b_out_nxt;
        end
    end

    // Next values of every registered output are computed here so outputs stay glitch-free.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        idx_nxt   = idx;
        t_nxt     = T;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        b_out_nxt = b_out;

        case (state)
            IDLE: begin
                t_nxt    = '0;
                busy_nxt = 1'b0;
                hold_nxt = '0;
                idx_nxt  = '0;
                if (start && !abort) begin
                    state_nxt = CLR;
                    t_nxt     = PULSES'(1);
                    busy_nxt  = 1'b1;
                    b_out_nxt = b_in;
                end
            end

            CLR, SET: begin
                if (abort) begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                    busy_nxt  = 1'b0;
                    hold_nxt  = '0;
                    idx_nxt   = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else begin
                    hold_nxt = '0;
                    if (state == SET && idx == IDX_LAST) begin
                        state_nxt = DONE;
                        t_nxt     = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        // Pulses are adjacent: shifting hands off to the next bit in one edge.
                        state_nxt = SET;
                        idx_nxt   = idx + 1'b1;
                        t_nxt     = T << 1;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                t_nxt     = '0;
                busy_nxt  = 1'b0;
                hold_nxt  = '0;
                idx_nxt   = '0;
            end

            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
                busy_nxt  = 1'b0;
                hold_nxt  = '0;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_comp_pulse_seq.sv
// Directed bench for comp_pulse_seq: one instance with HOLD=1, one with HOLD=3,
// plus a behavioural latch complementer driven by each T/b_out pair.
module tb_comp_pulse_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, abort1, busy1, done1;
    logic [7:0] b_in1, b_out1;
    logic [8:0] T1;
    logic       start3, abort3, busy3, done3;
    logic [7:0] b_in3, b_out3;
    logic [8:0] T3;

    comp_pulse_seq #(.N_BITS(8), .PULSES(9), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .b_in(b_in1), .b_out(b_out1), .T(T1), .busy(busy1), .done(done1)
    );

    comp_pulse_seq #(.N_BITS(8), .PULSES(9), .HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .b_in(b_in3), .b_out(b_out3), .T(T3), .busy(busy3), .done(done3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q1 = 8'h00;
    logic [7:0] q3 = 8'h00;
    int busy3_cnt = 0;

    // Downstream complementer: T[0] clears, T[k] latches the inverse of B[k-1].
    always @(negedge clk) begin
        if (T1[0]) q1 = 8'h00;
        for (int k = 1; k <= 8; k++) if (T1[k]) q1[k-1] = ~b_out1[k-1];
        if (T3[0]) q3 = 8'h00;
        for (int k = 1; k <= 8; k++) if (T3[k]) q3[k-1] = ~b_out3[k-1];
        if (busy3) busy3_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses1(input int from, input int to, input logic [7:0] bexp);
        for (int i = from; i <= to; i++) begin
            check("t1_pulse", 32'(T1), 32'(1) << i);
            check("t1_busy", 32'(busy1), 32'd1);
            check("t1_nodone", 32'(done1), 32'd0);
            check("t1_bout", 32'(b_out1), 32'(bexp));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; b_in1 = 8'h00;
        start3 = 1'b0; abort3 = 1'b0; b_in3 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_T", 32'(T1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_bout", 32'(b_out1), 32'd0);

        // Start on the first edge after reset release; HOLD=1 basic run.
        rst_n = 1'b1; b_in1 = 8'hA5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pulses1(0, 8, 8'hA5);
        check("a5_done", 32'(done1), 32'd1);
        check("a5_T0", 32'(T1), 32'd0);
        check("a5_busy", 32'(busy1), 32'd1);
        check("a5_result", 32'(q1), 32'h5A);
        tick();
        check("a5_idle_busy", 32'(busy1), 32'd0);
        check("a5_idle_done", 32'(done1), 32'd0);

        // Abort while T[4] is high.
        b_in1 = 8'h33; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pulses1(0, 3, 8'h33);
        check("ab_T10", 32'(T1), 32'h010);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("ab_T", 32'(T1), 32'd0);
        check("ab_busy", 32'(busy1), 32'd0);
        check("ab_bout", 32'(b_out1), 32'h33);
        for (int i = 0; i < 12; i++) begin
            check("ab_nodone", 32'(done1), 32'd0);
            tick();
        end
        b_in1 = 8'h0F; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pulses1(0, 8, 8'h0F);
        check("ab2_done", 32'(done1), 32'd1);
        check("ab2_result", 32'(q1), 32'hF0);
        tick();

        // start during SET is ignored, then start+abort in IDLE is ignored.
        b_in1 = 8'h81; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pulses1(0, 1, 8'h81);
        start1 = 1'b1; b_in1 = 8'h7E;
        tick();
        start1 = 1'b0;
        pulses1(3, 8, 8'h81);
        check("set_done", 32'(done1), 32'd1);
        check("set_result", 32'(q1), 32'h7E);
        tick();
        start1 = 1'b1; abort1 = 1'b1;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        check("sa_T", 32'(T1), 32'd0);
        check("sa_busy", 32'(busy1), 32'd0);
        check("sa_bout", 32'(b_out1), 32'h81);
        tick();
        check("sa_T2", 32'(T1), 32'd0);

        // start held high: back-to-back runs, b_in change picked up by the second.
        b_in1 = 8'hC3; start1 = 1'b1;
        tick();
        b_in1 = 8'h3C;
        pulses1(0, 8, 8'hC3);
        check("bb_done", 32'(done1), 32'd1);
        check("bb_result", 32'(q1), 32'h3C);
        tick();
        check("bb_gap_T", 32'(T1), 32'd0);
        check("bb_gap_busy", 32'(busy1), 32'd0);
        check("bb_gap_bout", 32'(b_out1), 32'hC3);
        tick();
        start1 = 1'b0;
        pulses1(0, 8, 8'h3C);
        check("bb2_done", 32'(done1), 32'd1);
        check("bb2_result", 32'(q1), 32'hC3);
        tick();

        // Asynchronous reset while T[2] is high.
        b_in1 = 8'h55; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pulses1(0, 1, 8'h55);
        check("rs_T4", 32'(T1), 32'h004);
        #2 rst_n = 1'b0;
        #1;
        check("rs_T", 32'(T1), 32'd0);
        check("rs_busy", 32'(busy1), 32'd0);
        check("rs_bout", 32'(b_out1), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            check("rs_nodone", 32'(done1), 32'd0);
            check("rs_idle_T", 32'(T1), 32'd0);
            tick();
        end

        // HOLD=3 with zero operand.
        b_in3 = 8'h00; start3 = 1'b1; busy3_cnt = 0;
        tick();
        start3 = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                check("h3_pulse", 32'(T3), 32'(1) << i);
                tick();
            end
        end
        check("h3_done", 32'(done3), 32'd1);
        check("h3_T0", 32'(T3), 32'd0);
        check("h3_result", 32'(q3), 32'hFF);
        tick();
        check("h3_idle", 32'(busy3), 32'd0);
        check("h3_busy_len", 32'(busy3_cnt), 32'd28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
